// File: rtl/caxi4interconnect_dwc_pkg.sv
// rtl/caxi4interconnect_dwc_pkg.sv - shared AXI encodings and sequencer state type for the width converter
package caxi4interconnect_dwc_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

endpackage

// File: rtl/dwc_upconv_addr_step.sv
// rtl/dwc_upconv_addr_step.sv - next byte offset within the wide word and wide-FIFO pop decision
module dwc_upconv_addr_step
  import caxi4interconnect_dwc_pkg::*;
#(
  parameter int OFS_W = 4
) (
  input  logic [OFS_W-1:0] cur_ofs,
  input  logic [2:0]       size,
  input  logic [1:0]       burst,
  input  logic [7:0]       len,
  input  logic             last,
  output logic [OFS_W-1:0] next_ofs,
  output logic             pop
);

  localparam int WORD_BYTES = 1 << OFS_W;

  logic [OFS_W:0]   step;
  logic [OFS_W:0]   aligned;
  logic [OFS_W:0]   sum;
  logic [15:0]      container;
  logic [OFS_W-1:0] wmask;
  logic             small_wrap;

  always_comb begin
    step       = {{OFS_W{1'b0}}, 1'b1} << size;
    aligned    = {1'b0, cur_ofs} & ~(step - 1'b1);
    sum        = aligned + step;
    container  = ({8'd0, len} + 16'd1) << size;
    // A wrap container at least as large as the wide word never wraps inside it.
    small_wrap = (burst == BURST_WRAP) && (container < 16'(WORD_BYTES));
    wmask      = container[OFS_W-1:0] - 1'b1;

    next_ofs = sum[OFS_W-1:0];
    if (burst == BURST_FIXED) begin
      next_ofs = cur_ofs;
    end else if (small_wrap) begin
      next_ofs = (aligned[OFS_W-1:0] & ~wmask) | (sum[OFS_W-1:0] & wmask);
    end

    pop = last || (burst == BURST_FIXED) || (sum[OFS_W] && !small_wrap);
  end

endmodule

// File: rtl/dwc_upconv_rchan_seq.sv
// rtl/dwc_upconv_rchan_seq.sv - wide-to-narrow R channel sequencer: FSM, beat counter, narrow output register
// Optional: define DWC_UPCONV_RRESP_EN to forward the FIFO head RRESP onto MASTER_RRESP.
module dwc_upconv_rchan_seq
  import caxi4interconnect_dwc_pkg::*;
#(
  parameter int  DATA_WIDTH_IN  = 128,
  parameter int  DATA_WIDTH_OUT = 32,
  parameter int  ID_WIDTH       = 4,
  localparam int RATIO          = DATA_WIDTH_IN / DATA_WIDTH_OUT,
  localparam int OFS_W          = $clog2(DATA_WIDTH_IN / 8)
) (
  input  logic                     ACLK,
  input  logic                     sysReset,
  input  logic                     cmd_valid,
  input  logic [OFS_W-1:0]         cmd_addr,
  input  logic [7:0]               cmd_len,
  input  logic [2:0]               cmd_size,
  input  logic [1:0]               cmd_burst,
  input  logic [ID_WIDTH-1:0]      cmd_id,
  output logic                     cmd_rd_en,
  input  logic                     data_empty,
  input  logic [1:0]               data_rresp,
  output logic                     data_rd_en,
  input  logic                     data_space,
  output logic                     SLAVE_RREADY,
  output logic                     out_load,
  output logic [$clog2(RATIO)-1:0] rd_src,
  output logic                     MASTER_RVALID,
  input  logic                     MASTER_RREADY,
  output logic                     MASTER_RLAST,
  output logic [ID_WIDTH-1:0]      MASTER_RID,
  output logic [1:0]               MASTER_RRESP
);

  localparam int LANE_LSB = $clog2(DATA_WIDTH_OUT / 8);

  state_t              state;
  logic [OFS_W-1:0]    cur_ofs;
  logic [OFS_W-1:0]    next_ofs;
  logic [7:0]          len_q;
  logic [7:0]          beat;
  logic [2:0]          size_q;
  logic [1:0]          burst_q;
  logic [ID_WIDTH-1:0] id_q;
  logic                last_beat;
  logic                pop;
  logic                advance;

  assign advance    = (state == ACTIVE) && !data_empty && (!MASTER_RVALID || MASTER_RREADY);
  assign last_beat  = (beat == len_q);
  assign out_load   = advance;
  assign data_rd_en = advance && pop;
  assign rd_src     = cur_ofs[OFS_W-1:LANE_LSB];

  dwc_upconv_addr_step #(
    .OFS_W(OFS_W)
  ) u_addr_step (
    .cur_ofs (cur_ofs),
    .size    (size_q),
    .burst   (burst_q),
    .len     (len_q),
    .last    (last_beat),
    .next_ofs(next_ofs),
    .pop     (pop)
  );

`ifndef DWC_UPCONV_RRESP_EN
  logic unused_rresp;
  assign unused_rresp = ^data_rresp;
  assign MASTER_RRESP = RESP_OKAY;
`endif

  always_ff @(posedge ACLK or negedge sysReset) begin
    if (!sysReset) begin
      state         <= IDLE;
      cmd_rd_en     <= 1'b0;
      SLAVE_RREADY  <= 1'b0;
      MASTER_RVALID <= 1'b0;
      MASTER_RLAST  <= 1'b0;
      MASTER_RID    <= '0;
      cur_ofs       <= '0;
      beat          <= '0;
      len_q         <= '0;
      size_q        <= '0;
      burst_q       <= '0;
      id_q          <= '0;
`ifdef DWC_UPCONV_RRESP_EN
      MASTER_RRESP  <= RESP_OKAY;
`endif
    end else begin
      cmd_rd_en    <= 1'b0;
      SLAVE_RREADY <= data_space;
      if (MASTER_RVALID && MASTER_RREADY) begin
        MASTER_RVALID <= 1'b0;
      end
      case (state)
        IDLE: begin
          // Command FIFO is popped one cycle after its head is latched.
          if (cmd_valid) begin
            state     <= ACTIVE;
            cmd_rd_en <= 1'b1;
            cur_ofs   <= cmd_addr;
            len_q     <= cmd_len;
            size_q    <= cmd_size;
            burst_q   <= cmd_burst;
            id_q      <= cmd_id;
            beat      <= '0;
          end
        end
        ACTIVE: begin
          if (advance) begin
            MASTER_RVALID <= 1'b1;
            MASTER_RLAST  <= last_beat;
            MASTER_RID    <= id_q;
`ifdef DWC_UPCONV_RRESP_EN
            MASTER_RRESP  <= data_rresp;
`endif
            cur_ofs       <= next_ofs;
            beat          <= beat + 8'd1;
            if (last_beat) begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dwc_upconv_rchan_seq.sv
// tb/tb_dwc_upconv_rchan_seq.sv - scoreboard bench: bench-owned FIFOs and datapath, address-level reference model
module tb_dwc_upconv_rchan_seq;

  localparam int WB = 16;
  localparam int NB = 4;
  localparam logic [1:0] B_FIXED = 2'b00;
  localparam logic [1:0] B_INCR  = 2'b01;
  localparam logic [1:0] B_WRAP  = 2'b10;

  typedef struct packed {logic [127:0] data; logic [1:0] resp;} word_t;
  typedef struct packed {logic [3:0] addr; logic [7:0] len; logic [2:0] size; logic [1:0] burst; logic [3:0] id;} cmd_t;
  typedef struct packed {logic [31:0] data; logic last; logic [3:0] id; logic [1:0] resp;} exp_t;

  logic ACLK = 1'b0;
  logic sysReset = 1'b0;
  logic cmd_valid, cmd_rd_en, data_empty, data_rd_en, data_space, SLAVE_RREADY, out_load;
  logic [3:0] cmd_addr, cmd_id, MASTER_RID;
  logic [7:0] cmd_len;
  logic [2:0] cmd_size;
  logic [1:0] cmd_burst, data_rresp, rd_src, MASTER_RRESP;
  logic MASTER_RVALID, MASTER_RREADY, MASTER_RLAST;

  always #5 ACLK = ~ACLK;

  dwc_upconv_rchan_seq #(.DATA_WIDTH_IN(128), .DATA_WIDTH_OUT(32), .ID_WIDTH(4)) dut (
    .ACLK(ACLK), .sysReset(sysReset),
    .cmd_valid(cmd_valid), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size),
    .cmd_burst(cmd_burst), .cmd_id(cmd_id), .cmd_rd_en(cmd_rd_en),
    .data_empty(data_empty), .data_rresp(data_rresp), .data_rd_en(data_rd_en),
    .data_space(data_space), .SLAVE_RREADY(SLAVE_RREADY), .out_load(out_load), .rd_src(rd_src),
    .MASTER_RVALID(MASTER_RVALID), .MASTER_RREADY(MASTER_RREADY), .MASTER_RLAST(MASTER_RLAST),
    .MASTER_RID(MASTER_RID), .MASTER_RRESP(MASTER_RRESP)
  );

  int n_pass = 0;
  int n_total = 0;
  word_t dq[$];
  cmd_t  cq[$];
  exp_t  expq[$];
  logic [31:0] rdata_model = '0;
  bit stall = 0, rnd = 0, hold_done = 0, gap_chk = 0, gap_on = 0, prev_acc_nonlast = 0;
  int rready_mode = 0, hold_cnt = 0, beat_acc = 0, gap = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, req);
  endtask

  task automatic drive();
    cmd_valid = cq.size() > 0;
    if (cq.size() > 0) begin
      cmd_addr = cq[0].addr; cmd_len = cq[0].len; cmd_size = cq[0].size;
      cmd_burst = cq[0].burst; cmd_id = cq[0].id;
    end
    data_empty = (dq.size() == 0) || stall;
    data_rresp = (dq.size() > 0) ? dq[0].resp : 2'b00;
  endtask

  // Reference: absolute byte address per beat, word index = address / word bytes.
  task automatic issue(input int addr, input int len, input int size, input logic [1:0] burst,
                       input logic [3:0] id, input bit rand_resp, input int err_word);
    int step, c, base, al, a, w, nw;
    int wi[$];
    int li[$];
    word_t ws[$];
    word_t wd;
    exp_t e;
    cmd_t cm;
    step = 1 << size;
    c = (len + 1) * step;
    for (int i = 0; i <= len; i++) begin
      al = (addr / step) * step;
      if (burst == B_FIXED) begin
        a = addr; w = i;
      end else if (burst == B_WRAP && c < WB) begin
        base = (addr / c) * c;
        a = (i == 0) ? addr : base + ((al - base + i * step) % c);
        w = 0;
      end else begin
        a = (i == 0) ? addr : al + i * step;
        w = a / WB;
        a = a % WB;
      end
      wi.push_back(w);
      li.push_back(a / NB);
    end
    nw = wi[len] + 1;
    for (int k = 0; k < nw; k++) begin
      wd.data = {$urandom, $urandom, $urandom, $urandom};
      wd.resp = rand_resp ? 2'($urandom_range(3)) : ((k == err_word) ? 2'b10 : 2'b00);
      ws.push_back(wd);
      dq.push_back(wd);
    end
    cm.addr = 4'(addr); cm.len = 8'(len); cm.size = 3'(size); cm.burst = burst; cm.id = id;
    cq.push_back(cm);
    for (int i = 0; i <= len; i++) begin
      e.data = 32'(ws[wi[i]].data >> (32 * li[i]));
      e.last = (i == len);
      e.id = id;
`ifdef DWC_UPCONV_RRESP_EN
      e.resp = ws[wi[i]].resp;
`else
      e.resp = 2'b00;
`endif
      expq.push_back(e);
    end
  endtask

  task automatic wait_drain(input int maxc);
    int c = 0;
    while ((expq.size() != 0 || cq.size() != 0) && c < maxc) begin
      @(negedge ACLK);
      c++;
    end
    chk("drain_pending_beats", expq.size(), 0);
    repeat (2) @(negedge ACLK);
  endtask

  // Bench-side FIFOs and datapath: act at posedge+1 on what the DUT asked for before the edge.
  initial begin : fifo_proc
    logic ld, pp, cr;
    logic [1:0] ln;
    forever begin
      @(negedge ACLK);
      ld = out_load; pp = data_rd_en; cr = cmd_rd_en; ln = rd_src;
      @(posedge ACLK);
      #1;
      if (sysReset) begin
        if (ld && dq.size() > 0) rdata_model = 32'(dq[0].data >> (32 * ln));
        if (pp) begin
          chk("pop_nonempty_fifo", dq.size() > 0, 1'b1);
          if (dq.size() > 0) void'(dq.pop_front());
        end
        if (cr && cq.size() > 0) void'(cq.pop_front());
      end
      if (rnd) begin
        stall = ($urandom_range(3) == 0);
        data_space = 1'($urandom_range(1));
      end else begin
        stall = 0;
        data_space = 1'b1;
      end
      case (rready_mode)
        1: MASTER_RREADY = ($urandom_range(9) < 7);
        2: begin
          if (hold_cnt > 0) begin
            MASTER_RREADY = 1'b0; hold_cnt--;
          end else if (!hold_done && beat_acc == 3) begin
            MASTER_RREADY = 1'b0; hold_cnt = 4; hold_done = 1;
          end else MASTER_RREADY = 1'b1;
        end
        default: MASTER_RREADY = 1'b1;
      endcase
      drive();
    end
  end

  bit prev_stall = 0, have_prev = 0;
  logic prev_space, pl;
  logic [3:0] pid;
  logic [1:0] presp;
  logic [31:0] prdata;
  exp_t mon_e;

  always @(negedge ACLK) begin
    if (!sysReset) begin
      prev_stall = 0; have_prev = 0; gap_on = 0; prev_acc_nonlast = 0;
    end else begin
      if (have_prev) chk("slave_rready", SLAVE_RREADY, prev_space);
      prev_space = data_space; have_prev = 1;
      if (prev_stall) begin
        chk("hold_rvalid", MASTER_RVALID, 1'b1);
        chk("hold_rlast", MASTER_RLAST, pl);
        chk("hold_rid", MASTER_RID, pid);
        chk("hold_rresp", MASTER_RRESP, presp);
        chk("hold_rdata", rdata_model, prdata);
      end
      if (MASTER_RVALID && !MASTER_RREADY) chk("hold_no_pop_load", {out_load, data_rd_en}, 2'b00);
      if (gap_chk && prev_acc_nonlast) chk("steady_rvalid", MASTER_RVALID, 1'b1);
      if (MASTER_RVALID && gap_on) begin
        if (gap_chk) chk("burst_gap_cycles", gap, 1);
        gap_on = 0;
      end else if (!MASTER_RVALID && gap_on) gap++;
      prev_acc_nonlast = 0;
      if (MASTER_RVALID && MASTER_RREADY) begin
        chk("beat_expected", expq.size() > 0, 1'b1);
        if (expq.size() > 0) begin
          mon_e = expq.pop_front();
          chk("rdata", rdata_model, mon_e.data);
          chk("rlast", MASTER_RLAST, mon_e.last);
          chk("rid", MASTER_RID, mon_e.id);
          chk("rresp", MASTER_RRESP, mon_e.resp);
        end
        if (MASTER_RLAST) begin
          beat_acc = 0; gap_on = 1; gap = 0;
        end else begin
          beat_acc++; prev_acc_nonlast = 1;
        end
      end
      prev_stall = MASTER_RVALID && !MASTER_RREADY;
      pl = MASTER_RLAST; pid = MASTER_RID; presp = MASTER_RRESP; prdata = rdata_model;
    end
  end

  always @(posedge ACLK) begin
    if (sysReset && cmd_valid)
      assert (!((cmd_burst == B_WRAP && cmd_len > 8'd15) || cmd_size > 3'd2))
        else $error("unsupported command len=%0d size=%0d burst=%0d", cmd_len, cmd_size, cmd_burst);
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rvalid"}, MASTER_RVALID, 1'b0);
    chk({tag, "_rlast"}, MASTER_RLAST, 1'b0);
    chk({tag, "_rid"}, MASTER_RID, 4'd0);
    chk({tag, "_rresp"}, MASTER_RRESP, 2'd0);
    chk({tag, "_slave_rready"}, SLAVE_RREADY, 1'b0);
    chk({tag, "_cmd_rd_en"}, cmd_rd_en, 1'b0);
    chk({tag, "_data_rd_en"}, data_rd_en, 1'b0);
    chk({tag, "_out_load"}, out_load, 1'b0);
  endtask

  initial begin
    int lat, t;
    data_space = 1'b1;
    MASTER_RREADY = 1'b1;
    drive();
    repeat (3) @(posedge ACLK);
    #2;
    chk_all_zero("reset");
    sysReset = 1'b1;

    // Directed back-to-back bursts with ready high: latency, gap and steady throughput.
    gap_chk = 1;
    @(negedge ACLK);
    issue(4, 7, 2, B_INCR, 4'h3, 0, 1);
    issue(6, 3, 1, B_WRAP, 4'h5, 0, -1);
    issue(8, 2, 2, B_FIXED, 4'hA, 0, -1);
    @(posedge ACLK);
    #2;
    lat = 0;
    do begin
      @(negedge ACLK);
      lat++;
    end while (!MASTER_RVALID && lat < 10);
    chk("first_beat_latency", lat, 3);
    wait_drain(200);
    gap_chk = 0;

    // Ready held low for 5 cycles at beat 3.
    hold_done = 0;
    rready_mode = 2;
    @(negedge ACLK);
    issue(4, 7, 2, B_INCR, 4'h6, 0, -1);
    wait_drain(200);
    rready_mode = 0;

    // Randomized traffic with throttling on both sides.
    rnd = 1;
    rready_mode = 1;
    for (int n = 0; n < 40; n++) begin
      int b, sz, ln;
      b = $urandom_range(2);
      sz = $urandom_range(2);
      if (b == 2) ln = (1 << ($urandom_range(3) + 1)) - 1;
      else if (b == 0) ln = $urandom_range(7);
      else ln = $urandom_range(19);
      @(negedge ACLK);
      issue($urandom_range(15), ln, sz, 2'(b), 4'($urandom_range(15)), 1, -1);
      repeat ($urandom_range(8)) @(negedge ACLK);
    end
    wait_drain(4000);
    rnd = 0;
    rready_mode = 0;
    repeat (2) @(negedge ACLK);

    // Reset in the middle of a burst, then a fresh burst.
    @(negedge ACLK);
    issue(0, 7, 2, B_INCR, 4'h5, 0, -1);
    t = 0;
    while (!(beat_acc == 4 && MASTER_RVALID) && t < 200) begin
      @(posedge ACLK);
      #2;
      t++;
    end
    chk("mid_burst_beat4_reached", t < 200, 1'b1);
    sysReset = 1'b0;
    #1;
    chk_all_zero("midreset");
    @(negedge ACLK);
    dq.delete();
    cq.delete();
    expq.delete();
    rdata_model = '0;
    beat_acc = 0;
    repeat (2) @(posedge ACLK);
    #2;
    sysReset = 1'b1;
    @(negedge ACLK);
    issue(8, 3, 2, B_INCR, 4'h9, 0, -1);
    wait_drain(200);

    chk("data_fifo_consumed", dq.size(), 0);
    chk("cmd_fifo_consumed", cq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
